mem_rd_seq: RTL and testbench

- Read-side counterpart of the cnt1 memory-write sequencer.
- On a request, walks a burst of addresses over the same csn/we/addr memory bus, paced by the `en` strobe, and reads one word per strobe.
- Captures each word and presents it on a valid/ready stream toward downstream logic.
- Sits beside the write sequencer on the shared small SRAM; 5-bit state is exported on `st` for debug.

---
 rtl/mem_rd_seq_pkg.sv | 22 ++
 rtl/mem_rd_seq_if.sv | 34 +++
 rtl/mem_rd_seq_ctr.sv | 31 +++
 rtl/mem_rd_seq.sv | 118 +++++++++++
 tb/tb_mem_rd_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rd_seq_pkg.sv
// mem_rd_seq_pkg: state encoding and configuration checks shared by the read sequencer
package mem_rd_seq_pkg;

    localparam int ST_W = 5;

    typedef enum logic [ST_W-1:0] {
        IDLE         = 5'd0,
        ARM          = 5'd1,
        ISSUE        = 5'd2,
        WAIT         = 5'd3,
        CAP          = 5'd4,
        HOLD         = 5'd5,
        DONE         = 5'd6,
        WAIT_REQ_LOW = 5'd7,
        CLR          = 5'd8
    } state_t;

    function automatic bit rd_lat_ok(input int lat);
        return lat == 1 || lat == 2;
    endfunction

endpackage

// File: rtl/mem_rd_seq_if.sv
// mem_rd_seq_if: SRAM bus plus output stream; wdata only exists with MEM_RD_SEQ_CLR_ON_READ_EN
interface mem_rd_seq_if #(
    parameter int AW = 5,
    parameter int DW = 8
);

    logic          csn;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
    logic [DW-1:0] wdata;
`endif
    logic [DW-1:0] dout;
    logic          dvld;
    logic          drdy;

    modport master (
        output csn, we, addr, dout, dvld,
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
        output wdata,
`endif
        input  rdata, drdy
    );

    modport slave (
        input  csn, we, addr, dout, dvld,
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
        input  wdata,
`endif
        output rdata, drdy
    );

endinterface

// File: rtl/mem_rd_seq_ctr.sv
// mem_rd_seq_ctr: burst address and word counter with load-to-BASE, wrapping increment and last-word flag
module mem_rd_seq_ctr #(
    parameter int AW   = 5,
    parameter int BASE = 0,
    parameter int LEN  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ld,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int CW = AW + 1;

    logic [CW-1:0] cnt;

    // load wins over increment; the address wraps naturally at 2**AW
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            addr <= AW'(BASE);
            cnt  <= '0;
        end else if (ld || inc) begin
            addr <= ld ? AW'(BASE) : addr + AW'(1);
            cnt  <= ld ? '0 : cnt + CW'(1);
        end

    assign last = cnt == CW'(LEN - 1);

endmodule

// File: rtl/mem_rd_seq.sv
// mem_rd_seq: en-paced burst reader streaming words out over valid/ready; MEM_RD_SEQ_CLR_ON_READ_EN adds clear-after-read
module mem_rd_seq
    import mem_rd_seq_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int BASE   = 0,
    parameter int LEN    = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req,
    input  logic            en,
    mem_rd_seq_if.master    bus,
    output logic            done,
    output logic [ST_W-1:0] st
);

    if (!rd_lat_ok(RD_LAT) || LEN < 1 || LEN > 2**AW) begin : g_cfg_err
        $error("mem_rd_seq: illegal RD_LAT or LEN");
    end

    state_t        state;
    logic [AW-1:0] addr;
    logic          last;
    logic          xfer;
    logic          ld;
    logic          inc;
    logic          csn_q;
    logic          dvld_q;
    logic [DW-1:0] dout_q;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
    logic          we_q;
`endif

    assign xfer = state == HOLD && dvld_q && bus.drdy;
    assign ld   = state == DONE || (state == ARM && !req) || (xfer && !last && !req);
    assign inc  = xfer && !last && req;

    mem_rd_seq_ctr #(.AW(AW), .BASE(BASE), .LEN(LEN)) u_ctr (
        .clk  (clk),
        .rstn (rstn),
        .ld   (ld),
        .inc  (inc),
        .addr (addr),
        .last (last)
    );

    // sequencer: csn/we are set on entry to the state that owns the bus cycle so they stay registered
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state  <= IDLE;
            csn_q  <= 1'b1;
            dout_q <= '0;
            dvld_q <= 1'b0;
            done   <= 1'b0;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
            we_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req) state <= ARM;
                ARM:
                    if (!req) state <= IDLE;
                    else if (en) begin
                        state <= ISSUE;
                        csn_q <= 1'b0;
                    end
                ISSUE: begin
                    csn_q <= 1'b1;
                    state <= RD_LAT == 2 ? WAIT : CAP;
                end
                WAIT: state <= CAP;
                CAP: begin
                    dout_q <= bus.rdata;
                    dvld_q <= 1'b1;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
                    state  <= CLR;
                    csn_q  <= 1'b0;
                    we_q   <= 1'b1;
`else
                    state  <= HOLD;
`endif
                end
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
                CLR: begin
                    csn_q <= 1'b1;
                    we_q  <= 1'b0;
                    state <= HOLD;
                end
`endif
                HOLD:
                    if (xfer) begin
                        dvld_q <= 1'b0;
                        done   <= last;
                        state  <= last ? DONE : req ? ARM : IDLE;
                    end
                DONE: state <= req ? WAIT_REQ_LOW : IDLE;
                WAIT_REQ_LOW: if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    assign bus.csn  = csn_q;
    assign bus.addr = addr;
    assign bus.dout = dout_q;
    assign bus.dvld = dvld_q;
    assign st       = state;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
    assign bus.we    = we_q;
    assign bus.wdata = '0;
`else
    assign bus.we    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rd_seq.sv
// tb_mem_rd_seq: two sequencers (BASE=0/RD_LAT=1 and BASE=30/RD_LAT=2) under shared directed stimulus
module tb_mem_rd_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req = 1'b0;
    logic       en = 1'b0;
    logic       drdy = 1'b1;
    logic       done_a, done_b;
    logic [4:0] st_a, st_b;

    always #5 clk = ~clk;

    mem_rd_seq_if #(.AW(5), .DW(8)) ia ();
    mem_rd_seq_if #(.AW(5), .DW(8)) ib ();

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    logic [7:0] sh_a [32];
    logic [7:0] sh_b [32];
    logic [7:0] a1, b1, b2;

    always @(posedge clk) begin
        a1 <= (!ia.csn && !ia.we) ? mem_a[ia.addr] : 8'hEE;
        b1 <= (!ib.csn && !ib.we) ? mem_b[ib.addr] : 8'hEE;
        b2 <= b1;
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
        if (!ia.csn && ia.we) mem_a[ia.addr] <= ia.wdata;
        if (!ib.csn && ib.we) mem_b[ib.addr] <= ib.wdata;
`endif
    end

    assign ia.rdata = a1;
    assign ib.rdata = b2;
    assign ia.drdy  = drdy;
    assign ib.drdy  = drdy;

    mem_rd_seq #(.AW(5), .DW(8), .BASE(0), .LEN(4), .RD_LAT(1)) dut_a (
        .clk (clk), .rstn (rstn), .req (req), .en (en), .bus (ia), .done (done_a), .st (st_a)
    );

    mem_rd_seq #(.AW(5), .DW(8), .BASE(30), .LEN(4), .RD_LAT(2)) dut_b (
        .clk (clk), .rstn (rstn), .req (req), .en (en), .bus (ib), .done (done_b), .st (st_b)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         w = 0;
    int         t_cs [2];
    int         rd_cnt [2];
    int         we_cnt [2];
    int         done_cnt [2];
    logic [4:0] exp_addr [2];
    logic       pdvld [2];
    logic       pacc [2];
    logic [7:0] pdout [2];
    logic [7:0] qa [$];
    logic [7:0] qb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic mon(input int d, input int lat, input logic csn, input logic we,
                       input logic [4:0] addr, input logic [4:0] st, input logic [7:0] dout,
                       input logic dvld, input logic done);
        logic [7:0] e;
        if (!csn && !we) begin
            rd_cnt[d]++;
            t_cs[d] = cyc;
            chk($sformatf("addr%0d", d), 32'(addr), 32'(exp_addr[d]));
        end
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
        if (!csn && we) we_cnt[d]++;
`else
        if (!csn) chk($sformatf("we_low%0d", d), 32'(we), 0);
`endif
        if (cyc == t_cs[d] + 1) chk($sformatf("lat_st%0d", d), 32'(st), lat == 2 ? 3 : 4);
        if (dvld && !pdvld[d]) chk($sformatf("dvld_lat%0d", d), cyc - t_cs[d], lat + 1);
        if (dvld && pdvld[d] && !pacc[d]) chk($sformatf("dout_hold%0d", d), 32'(dout), 32'(pdout[d]));
        if (dvld && drdy) begin
            e = 'x;
            if (d == 0 && qa.size() > 0) e = qa.pop_front();
            if (d == 1 && qb.size() > 0) e = qb.pop_front();
            chk($sformatf("dout%0d", d), 32'(dout), 32'(e));
        end
        if (done) done_cnt[d]++;
        pdvld[d] = dvld;
        pdout[d] = dout;
        pacc[d]  = dvld && drdy;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon(0, 1, ia.csn, ia.we, ia.addr, st_a, ia.dout, ia.dvld, done_a);
        mon(1, 2, ib.csn, ib.we, ib.addr, st_b, ib.dout, ib.dvld, done_b);
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic fire(input bit push);
        en = 1'b1;
        if (push) begin
            exp_addr[0] = 5'(0 + w);
            exp_addr[1] = 5'(30 + w);
            qa.push_back(sh_a[exp_addr[0]]);
            qb.push_back(sh_b[exp_addr[1]]);
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
            sh_a[exp_addr[0]] = 8'h00;
            sh_b[exp_addr[1]] = 8'h00;
`endif
            w++;
        end
        step();
        en = 1'b0;
    endtask

    task automatic both(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] wa, input logic [31:0] wb);
        chk({tag, "_a"}, oa, wa);
        chk({tag, "_b"}, ob, wb);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 8'hA0 + 8'(i);
            mem_b[i] = 8'hA0 + 8'(i);
            sh_a[i]  = 8'hA0 + 8'(i);
            sh_b[i]  = 8'hA0 + 8'(i);
        end
        for (int d = 0; d < 2; d++) begin
            t_cs[d] = -100; rd_cnt[d] = 0; we_cnt[d] = 0; done_cnt[d] = 0;
            pdvld[d] = 1'b0; pacc[d] = 1'b0; pdout[d] = 8'h00; exp_addr[d] = 5'd0;
        end
        #12;
        both("rst_st", st_a, st_b, 0, 0);
        both("rst_csn", ia.csn, ib.csn, 1, 1);
        both("rst_dvld", ia.dvld, ib.dvld, 0, 0);
        both("rst_dout", ia.dout, ib.dout, 0, 0);
        both("rst_done", done_a, done_b, 0, 0);
        both("rst_addr", ia.addr, ib.addr, 0, 30);
        rstn = 1'b1;
        req = 1'b1;
        step();
        both("arm_st", st_a, st_b, 1, 1);
        // basic burst, four words with en every 10 cycles
        w = 0;
        repeat (4) begin
            fire(1);
            steps(9);
        end
        both("b1_done", done_cnt[0], done_cnt[1], 1, 1);
        both("b1_reads", rd_cnt[0], rd_cnt[1], 4, 4);
        both("b1_st", st_a, st_b, 7, 7);
        steps(3);
        both("no_retrig", st_a, st_b, 7, 7);
        req = 1'b0;
        step();
        both("idle_st", st_a, st_b, 0, 0);
        both("idle_addr", ia.addr, ib.addr, 0, 30);
        // back-pressure on the first word; stray en pulses must not issue reads
        req = 1'b1;
        step();
        w = 0;
        drdy = 1'b0;
        fire(1);
        steps(4);
        repeat (4) begin
            fire(0);
            steps(4);
        end
        both("bp_reads", rd_cnt[0], rd_cnt[1], 5, 5);
        both("bp_dvld", ia.dvld, ib.dvld, 1, 1);
        both("bp_st", st_a, st_b, 5, 5);
        drdy = 1'b1;
        steps(5);
        both("bp_arm", st_a, st_b, 1, 1);
        fire(1);
        both("bp_resume", rd_cnt[0], rd_cnt[1], 5, 5);
        step();
        both("bp_issued", rd_cnt[0], rd_cnt[1], 6, 6);
        steps(8);
        repeat (2) begin
            fire(1);
            steps(9);
        end
        both("b2_done", done_cnt[0], done_cnt[1], 2, 2);
        both("b2_st", st_a, st_b, 7, 7);
        req = 1'b0;
        step();
        // abort from ARM after one word
        req = 1'b1;
        step();
        w = 0;
        fire(1);
        steps(9);
        both("ab1_addr_inc", ia.addr, ib.addr, 1, 31);
        req = 1'b0;
        step();
        both("ab1_st", st_a, st_b, 0, 0);
        both("ab1_addr", ia.addr, ib.addr, 0, 30);
        // abort from HOLD: word still delivered, then IDLE without done
        req = 1'b1;
        step();
        w = 0;
        drdy = 1'b0;
        fire(1);
        steps(5);
        req = 1'b0;
        steps(3);
        both("ab2_hold", st_a, st_b, 5, 5);
        both("ab2_dvld", ia.dvld, ib.dvld, 1, 1);
        drdy = 1'b1;
        steps(2);
        both("ab2_st", st_a, st_b, 0, 0);
        both("ab2_dvld0", ia.dvld, ib.dvld, 0, 0);
        both("ab2_addr", ia.addr, ib.addr, 0, 30);
        both("ab_done", done_cnt[0], done_cnt[1], 2, 2);
        // asynchronous reset while holding a word
        req = 1'b1;
        step();
        w = 0;
        drdy = 1'b0;
        fire(0);
        steps(5);
        #2 rstn = 1'b0;
        #1;
        both("ar_csn", ia.csn, ib.csn, 1, 1);
        both("ar_dvld", ia.dvld, ib.dvld, 0, 0);
        both("ar_st", st_a, st_b, 0, 0);
        for (int d = 0; d < 2; d++) begin
            pdvld[d] = 1'b0; pacc[d] = 1'b0; t_cs[d] = -100;
        end
        #2 rstn = 1'b1;
        drdy = 1'b1;
        step();
        both("ar_arm", st_a, st_b, 1, 1);
        fire(1);
        steps(9);
        req = 1'b0;
        steps(6);
        both("sb_left", qa.size(), qb.size(), 0, 0);
`ifdef MEM_RD_SEQ_CLR_ON_READ_EN
        both("clr_we", we_cnt[0], we_cnt[1], rd_cnt[0], rd_cnt[1]);
        for (int i = 0; i < 4; i++) chk($sformatf("clr_mem%0d", i), 32'(mem_a[i]), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
